// File: rtl/ccc_pkg.sv
// ccc_pkg: shared state encoding and helpers for the CCC lock reset sequencer
package ccc_pkg;
  localparam int SEQ_STATE_W = 3;
  typedef enum logic [SEQ_STATE_W-1:0] {
    WAIT_LOCK = 3'd0,
    STABLE    = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3
  } seq_state_e;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/ccc_lock_reset_seq_lock_sync.sv
// lock_sync: N-stage flop synchronizer with asynchronous active-low clear
module lock_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] s;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) s <= '0;
    else s <= {s[STAGES-2:0], d};
  assign q = s[STAGES-1];
endmodule

// File: rtl/ccc_lock_reset_seq.sv
// ccc_lock_reset_seq: lock-qualified staged release of peripheral and fabric resets
module ccc_lock_reset_seq
  import ccc_pkg::*;
#(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RESET_HOLD_CYCLES  = 16,
  parameter bit REQUIRE_MSS_LOCK   = 1'b1,
  parameter int LOSS_CNT_W         = 8
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   FAB_LOCK,
  input  logic                   MSS_LOCK,
  input  logic                   CLR_LOST,
  output logic                   PERIPH_RESET_N,
  output logic                   FAB_RESET_N,
  output logic                   LOCK_OK,
  output logic                   LOCK_LOST,
  output logic [LOSS_CNT_W-1:0]  LOSS_COUNT,
  output logic [SEQ_STATE_W-1:0] SEQ_STATE
);
  localparam int MAX_CYC = LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES ? LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
  localparam int CNT_W = clog2(MAX_CYC) < 1 ? 1 : clog2(MAX_CYC);
  logic fab_s, mss_s, run_loss, st_done, rel_done;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  seq_state_e state, nxt;
  lock_sync #(.STAGES(SYNC_STAGES)) u_fab_sync (.clk(CLK), .rst_n(RESET_N), .d(FAB_LOCK), .q(fab_s));
  lock_sync #(.STAGES(SYNC_STAGES)) u_mss_sync (.clk(CLK), .rst_n(RESET_N), .d(MSS_LOCK), .q(mss_s));
  assign LOCK_OK   = fab_s & (mss_s | ~REQUIRE_MSS_LOCK);
  assign SEQ_STATE = state;
  assign st_done   = cnt == CNT_W'(LOCK_STABLE_CYCLES - 1);
  assign rel_done  = cnt == CNT_W'(RESET_HOLD_CYCLES - 1);
  assign run_loss  = (state == RUN) && !LOCK_OK;
  // Lock loss outranks any count completion in the same cycle.
  always_comb begin
    nxt = !LOCK_OK ? WAIT_LOCK :
          state == WAIT_LOCK ? STABLE :
          (state == STABLE && st_done) ? RELEASE :
          (state == RELEASE && rel_done) ? RUN : state;
    cnt_nxt = (nxt != state || state == WAIT_LOCK || state == RUN) ? '0 : cnt + 1'b1;
  end
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      state          <= WAIT_LOCK;
      cnt            <= '0;
      PERIPH_RESET_N <= 1'b0;
      FAB_RESET_N    <= 1'b0;
      LOCK_LOST      <= 1'b0;
      LOSS_COUNT     <= '0;
    end else begin
      state          <= nxt;
      cnt            <= cnt_nxt;
      PERIPH_RESET_N <= (nxt == RELEASE) || (nxt == RUN);
      FAB_RESET_N    <= nxt == RUN;
      LOCK_LOST      <= run_loss | (LOCK_LOST & ~CLR_LOST);
      LOSS_COUNT     <= LOSS_COUNT + LOSS_CNT_W'(run_loss && !(&LOSS_COUNT));
    end
endmodule

// File: tb/tb_ccc_lock_reset_seq.sv
// tb_ccc_lock_reset_seq: vector table, corner sequences and random run against a lock-history model
module tb_ccc_lock_reset_seq;
  localparam int S = 2, L = 8, R = 4, W = 2;
  logic clk = 1'b0, rst_n = 1'b0, fab = 1'b0, mss = 1'b0, clr = 1'b0;
  logic per0, per1, fr0, fr1, ok0, ok1, lost0, lost1;
  logic [W-1:0] loss0, loss1;
  logic [2:0] st0, st1;
  int n_tests = 0, n_fail = 0;
  int h[2], loss_m[2];
  bit lost_m[2];
  bit [S-1:0] hist[2];
  typedef struct {
    bit fab, mss, clr;
    int n;
    bit ok, per, fr;
    int st;
    bit lost;
    int loss;
  } vec_t;
  vec_t tbl[13];

  always #5 clk = ~clk;

  ccc_lock_reset_seq #(.SYNC_STAGES(S), .LOCK_STABLE_CYCLES(L), .RESET_HOLD_CYCLES(R),
    .REQUIRE_MSS_LOCK(1'b1), .LOSS_CNT_W(W)) u0 (
    .CLK(clk), .RESET_N(rst_n), .FAB_LOCK(fab), .MSS_LOCK(mss), .CLR_LOST(clr),
    .PERIPH_RESET_N(per0), .FAB_RESET_N(fr0), .LOCK_OK(ok0), .LOCK_LOST(lost0),
    .LOSS_COUNT(loss0), .SEQ_STATE(st0));
  ccc_lock_reset_seq #(.SYNC_STAGES(S), .LOCK_STABLE_CYCLES(L), .RESET_HOLD_CYCLES(R),
    .REQUIRE_MSS_LOCK(1'b0), .LOSS_CNT_W(W)) u1 (
    .CLK(clk), .RESET_N(rst_n), .FAB_LOCK(fab), .MSS_LOCK(mss), .CLR_LOST(clr),
    .PERIPH_RESET_N(per1), .FAB_RESET_N(fr1), .LOCK_OK(ok1), .LOCK_LOST(lost1),
    .LOSS_COUNT(loss1), .SEQ_STATE(st1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // h counts consecutive edges the sequencer has seen a qualified lock
  function automatic int st_of(input int hh);
    return hh == 0 ? 0 : hh <= L ? 1 : hh <= L + R ? 2 : 3;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      h[i] = 0; hist[i] = '0; lost_m[i] = 1'b0; loss_m[i] = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      bit lok, ev;
      lok = hist[i][S-1];
      ev = !lok && h[i] > L + R;
      h[i] = !lok ? 0 : (h[i] > L + R ? h[i] : h[i] + 1);
      if (ev) begin
        lost_m[i] = 1'b1;
        if (loss_m[i] < (1 << W) - 1) loss_m[i]++;
      end else if (clr) lost_m[i] = 1'b0;
      hist[i] = {hist[i][S-2:0], fab && (mss || i == 1)};
    end
  endtask

  task automatic check_model();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d_lock_ok", i), 32'(i == 0 ? ok0 : ok1), 32'(hist[i][S-1]));
      chk($sformatf("u%0d_periph", i), 32'(i == 0 ? per0 : per1), 32'(h[i] > L));
      chk($sformatf("u%0d_fab_rst", i), 32'(i == 0 ? fr0 : fr1), 32'(h[i] > L + R));
      chk($sformatf("u%0d_state", i), 32'(i == 0 ? st0 : st1), 32'(st_of(h[i])));
      chk($sformatf("u%0d_lost", i), 32'(i == 0 ? lost0 : lost1), 32'(lost_m[i]));
      chk($sformatf("u%0d_loss", i), 32'(i == 0 ? loss0 : loss1), 32'(loss_m[i]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    check_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_model();
    rst_n = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{1, 1, 0, 1, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 1, 0, 1, 1, 0, 0, 0, 0, 0};
    tbl[2]  = '{1, 1, 0, 1, 1, 0, 0, 1, 0, 0};
    tbl[3]  = '{1, 1, 0, 7, 1, 0, 0, 1, 0, 0};
    tbl[4]  = '{1, 1, 0, 1, 1, 1, 0, 2, 0, 0};
    tbl[5]  = '{1, 1, 0, 3, 1, 1, 0, 2, 0, 0};
    tbl[6]  = '{1, 1, 0, 1, 1, 1, 1, 3, 0, 0};
    tbl[7]  = '{1, 1, 0, 5, 1, 1, 1, 3, 0, 0};
    tbl[8]  = '{0, 1, 0, 1, 1, 1, 1, 3, 0, 0};
    tbl[9]  = '{0, 1, 0, 1, 0, 1, 1, 3, 0, 0};
    tbl[10] = '{0, 1, 0, 1, 0, 0, 0, 0, 1, 1};
    tbl[11] = '{0, 1, 1, 1, 0, 0, 0, 0, 0, 1};
    tbl[12] = '{0, 1, 0, 3, 0, 0, 0, 0, 0, 1};
    do_reset();
    chk("rst_periph", 32'(per0), 0);
    chk("rst_state", 32'(st0), 0);
    foreach (tbl[k]) begin
      fab = tbl[k].fab; mss = tbl[k].mss; clr = tbl[k].clr;
      repeat (tbl[k].n) step();
      clr = 1'b0;
      chk($sformatf("t%0d_ok", k), 32'(ok0), 32'(tbl[k].ok));
      chk($sformatf("t%0d_periph", k), 32'(per0), 32'(tbl[k].per));
      chk($sformatf("t%0d_fab_rst", k), 32'(fr0), 32'(tbl[k].fr));
      chk($sformatf("t%0d_state", k), 32'(st0), 32'(tbl[k].st));
      chk($sformatf("t%0d_lost", k), 32'(lost0), 32'(tbl[k].lost));
      chk($sformatf("t%0d_loss", k), 32'(loss0), 32'(tbl[k].loss));
    end
    // FAB_LOCK alone: only the instance ignoring MSS_LOCK may release
    fab = 1'b0; mss = 1'b0;
    do_reset();
    fab = 1'b1;
    repeat (14) step();
    chk("nomss_fab_rst_e13", 32'(fr1), 0);
    step();
    chk("nomss_fab_rst_e14", 32'(fr1), 1);
    repeat (30) step();
    chk("reqmss_ok_held", 32'(ok0), 0);
    chk("reqmss_periph_held", 32'(per0), 0);
    chk("reqmss_fab_rst_held", 32'(fr0), 0);
    // drop during STABLE at counter 5, then restart the full count
    fab = 1'b0;
    do_reset();
    fab = 1'b1; mss = 1'b1;
    repeat (8) step();
    chk("stdrop_in_stable", 32'(st0), 1);
    fab = 1'b0;
    repeat (3) step();
    chk("stdrop_wait", 32'(st0), 0);
    fab = 1'b1;
    repeat (10) step();
    chk("stdrop_periph_early", 32'(per0), 0);
    step();
    chk("stdrop_periph_rise", 32'(per0), 1);
    chk("stdrop_lost", 32'(lost0), 0);
    chk("stdrop_loss", 32'(loss0), 0);
    // repeated RUN losses saturate; last loss coincides with CLR_LOST
    fab = 1'b0;
    do_reset();
    for (int j = 0; j < 5; j++) begin
      fab = 1'b1;
      repeat (16) step();
      chk($sformatf("sat%0d_run", j), 32'(st0), 3);
      if (j == 4) begin
        clr = 1'b1; step(); clr = 1'b0;
        chk("sat_clr_in_run", 32'(lost0), 0);
      end
      fab = 1'b0;
      repeat (2) step();
      chk($sformatf("sat%0d_still_on", j), 32'(fr0), 1);
      clr = (j == 4);
      step();
      clr = 1'b0;
      chk($sformatf("sat%0d_fab_rst_low", j), 32'(fr0), 0);
      chk($sformatf("sat%0d_lost", j), 32'(lost0), 1);
      chk($sformatf("sat%0d_loss", j), 32'(loss0), 32'(j + 1 > 3 ? 3 : j + 1));
      repeat (2) step();
    end
    // reset mid-RELEASE with locks held high
    do_reset();
    fab = 1'b1; mss = 1'b1;
    repeat (12) step();
    chk("midrst_in_release", 32'(st0), 2);
    do_reset();
    chk("midrst_periph", 32'(per0), 0);
    chk("midrst_ok", 32'(ok0), 0);
    chk("midrst_state", 32'(st0), 0);
    repeat (10) step();
    chk("midrst_periph_e9", 32'(per0), 0);
    step();
    chk("midrst_periph_e10", 32'(per0), 1);
    repeat (3) step();
    chk("midrst_fab_rst_e13", 32'(fr0), 0);
    step();
    chk("midrst_fab_rst_e14", 32'(fr0), 1);
    // random sticky lock toggling, CLR pulses and rare resets
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 29) == 0) fab = ~fab;
      if ($urandom_range(0, 39) == 0) mss = ~mss;
      clr = $urandom_range(0, 19) == 0;
      if ($urandom_range(0, 999) == 0) do_reset();
      step();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ccc_lock_reset_seq.md
# ccc_lock_reset_seq

Lock-qualified reset sequencer for the fabric side of the MSS clock conditioning circuit. It synchronizes the CCC's FAB_LOCK and MSS_LOCK outputs into the fabric clock domain. It requires the combined lock to stay stable for a programmable time, then releases peripheral and fabric resets in two staged steps. On lock loss it re-asserts both resets and records the event.

## Interface
Parameters:
- SYNC_STAGES, 2: synchronizer depth for each lock input (≥2).
- LOCK_STABLE_CYCLES, 1024: cycles the combined lock must stay high before the first release (≥1).
- RESET_HOLD_CYCLES, 16: cycles between the PERIPH_RESET_N release and the FAB_RESET_N release (≥1).
- REQUIRE_MSS_LOCK, 1: 1 = qualify on FAB_LOCK & MSS_LOCK; 0 = FAB_LOCK only (MSS_LOCK ignored).
- LOSS_CNT_W, 8: width of the lock-loss counter.

Ports:
- CLK  input  1  fabric clock (CCC GLB/FAB_CLK); the only clock.
- RESET_N  input  1  asynchronous active-low reset.
- FAB_LOCK  input  1  CCC fabric lock; asynchronous to CLK.
- MSS_LOCK  input  1  CCC MSS lock; asynchronous to CLK.
- CLR_LOST  input  1  single-cycle pulse; clears LOCK_LOST.
- PERIPH_RESET_N  output  1  active-low peripheral reset; released first.
- FAB_RESET_N  output  1  active-low fabric reset; released last.
- LOCK_OK  output  1  synchronized, qualified lock.
- LOCK_LOST  output  1  sticky flag: lock dropped while in RUN.
- LOSS_COUNT  output  LOSS_CNT_W  saturating count of lock losses from RUN.
- SEQ_STATE  output  3  current state encoding, for debug.

## Operation
- LOCK_OK = synchronized FAB_LOCK AND (synchronized MSS_LOCK OR !REQUIRE_MSS_LOCK).
- State machine, encoding from package:
  - WAIT_LOCK: entered from reset. Cycle counter held at 0. If LOCK_OK=1, go to STABLE.
  - STABLE: counter increments each cycle. At counter == LOCK_STABLE_CYCLES-1, clear the counter and go to RELEASE.
  - RELEASE: counter increments. At counter == RESET_HOLD_CYCLES-1, clear the counter and go to RUN.
  - RUN: terminal state while lock holds.
  - In STABLE, RELEASE or RUN, LOCK_OK=0 forces WAIT_LOCK with counter cleared. This overrides any count completion in the same cycle.
- Reset outputs:
  - Dedicated flops, loaded from the next-state decode. No combinational decode drives them.
  - PERIPH_RESET_N=1 iff the state is RELEASE or RUN.
  - FAB_RESET_N=1 iff the state is RUN.
- Loss recording, on a RUN→WAIT_LOCK transition:
  - LOCK_LOST is set.
  - LOSS_COUNT increments, saturating at all-ones.
  - Losses from STABLE or RELEASE are not counted.
- CLR_LOST clears LOCK_LOST. If CLR_LOST and a RUN loss occur in the same cycle, the set wins.
- Counter width is clog2(max(LOCK_STABLE_CYCLES, RESET_HOLD_CYCLES)), minimum 1. The counter never wraps: it is always cleared before overflow.

## Timing
- Values after RESET_N assertion (asynchronous, immediate):
  - PERIPH_RESET_N=0, FAB_RESET_N=0.
  - LOCK_OK=0, LOCK_LOST=0, LOSS_COUNT=0.
  - SEQ_STATE=WAIT_LOCK.
  - All synchronizer flops 0.
- RESET_N deassertion is taken synchronously at the next CLK edge. It is the integrator's job to supply a synchronized deassert.
- Let edge 0 be the first edge at which the qualified lock inputs are sampled high. Then:
  - LOCK_OK rises after edge SYNC_STAGES-1.
  - STABLE is entered at edge SYNC_STAGES.
  - PERIPH_RESET_N rises at edge SYNC_STAGES+LOCK_STABLE_CYCLES.
  - FAB_RESET_N rises at edge SYNC_STAGES+LOCK_STABLE_CYCLES+RESET_HOLD_CYCLES.
- Lock drop: both resets fall at the edge after LOCK_OK falls. Worst case is SYNC_STAGES+1 edges after the input falls.
- A lock glitch shorter than one CLK period may or may not be seen. If seen, it restarts the full sequence.
- Reset mid-sequence: all state is abandoned; the sequence restarts from WAIT_LOCK.

## Structure
- Package ccc_pkg holds:
  - the state typedef: WAIT_LOCK=0, STABLE=1, RELEASE=2, RUN=3;
  - the SEQ_STATE width constant;
  - a clog2 helper function.
- Sub-module lock_sync: an N-stage flop synchronizer with async active-low clear. It is instantiated twice, once per lock input. ccc_lock_reset_seq holds the FSM, counter, loss logic and output flops.

## Test plan
Bench parameters: SYNC_STAGES=2, LOCK_STABLE_CYCLES=8, RESET_HOLD_CYCLES=4.
- Both locks rise together at edge 0 → PERIPH_RESET_N rises at edge 10, FAB_RESET_N at edge 14, SEQ_STATE=3.
- FAB_LOCK high, MSS_LOCK low, REQUIRE_MSS_LOCK=1 → LOCK_OK stays 0 and both resets stay 0 indefinitely. Same stimulus with REQUIRE_MSS_LOCK=0 → FAB_RESET_N rises at edge 14.
- Lock drops for 3 cycles during STABLE (counter=5), then returns → no LOCK_LOST, LOSS_COUNT=0, and the full 8-cycle stability count restarts.
- Lock drops in RUN → both resets low 3 edges after the input falls, LOCK_LOST=1, LOSS_COUNT=1. CLR_LOST pulse → LOCK_LOST=0, LOSS_COUNT unchanged.
- LOSS_CNT_W=2 with 5 RUN losses → LOSS_COUNT saturates at 3. A CLR_LOST pulse coincident with a loss leaves LOCK_LOST=1.
- RESET_N asserted mid-RELEASE → all outputs at reset values with no clock edge. After deassert with locks held high, the sequence completes with the same edge offsets as the first scenario.
